// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial-pattern detection controller.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;
  localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

endpackage

// File: rtl/seq_det_window.sv
// Bit history and fill tracking for the detector; flags a hit on the
// history as it will look after the current shift.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic               clear,
  input  logic               overlap,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LW-1:0]      len,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist_r;
  logic [MAX_LEN-1:0] hist_nxt_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [LW-1:0]      fill_r;
  logic [LW-1:0]      fill_nxt_s;

  // Next-state history, saturating fill and length-masked compare
  always_comb begin
    hist_nxt_s = {hist_r[MAX_LEN-2:0], bit_in};
    if (fill_r >= LW'(MAX_LEN)) begin
      fill_nxt_s = fill_r;
    end else begin
      fill_nxt_s = fill_r + LW'(1);
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len));
    end
    hit = shift && (fill_nxt_s >= len) &&
          ((hist_nxt_s & mask_s) == (pattern & mask_s));
  end

  // History/fill registers; a non-overlapping hit restarts the fill only,
  // the stale bits fall out of the compare until fill reaches len again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= {MAX_LEN{1'b0}};
      fill_r <= {LW{1'b0}};
    end else if (clear) begin
      hist_r <= {MAX_LEN{1'b0}};
      fill_r <= {LW{1'b0}};
    end else if (shift) begin
      hist_r <= hist_nxt_s;
      fill_r <= (hit && !overlap) ? {LW{1'b0}} : fill_nxt_s;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable pattern-detection controller: config registers, run FSM and
// match counter around the seq_det_window datapath.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         bit_valid,
  input  logic                         bit_in,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t             state_r, state_nxt_s;
  logic [MAX_LEN-1:0] pat_r;
  logic [LW-1:0]      len_r;
  logic               ovl_r;
  logic [CNT_W-1:0]   tgt_r;
  logic               cfg_ld_s, arm_s, err_s, cnt_inc_s;
  logic               shift_s, hit_s, start_ok_s;
  logic [CNT_W-1:0]   cnt_plus_s;

  assign start_ok_s = (len_r != {LW{1'b0}}) && (len_r <= LW'(MAX_LEN)) &&
                      (tgt_r != {CNT_W{1'b0}});
  assign shift_s    = (state_r == RUN) && bit_valid && !abort;
  assign cnt_plus_s = match_count + CNT_W'(1);

  seq_det_window #(.MAX_LEN(MAX_LEN), .LW(LW)) u_window (
    .clk     (clk),
    .rst     (rst),
    .shift   (shift_s),
    .clear   (arm_s),
    .overlap (ovl_r),
    .bit_in  (bit_in),
    .pattern (pat_r),
    .len     (len_r),
    .hit     (hit_s)
  );

  // Next-state and control strobes; abort > start > cfg_we
  always_comb begin
    state_nxt_s = state_r;
    cfg_ld_s    = 1'b0;
    arm_s       = 1'b0;
    err_s       = 1'b0;
    cnt_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (start) begin
          if (start_ok_s) begin
            state_nxt_s = RUN;
            arm_s       = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else if (cfg_we) begin
          cfg_ld_s = 1'b1;
        end else begin
          cfg_ld_s = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          err_s = cfg_we;
          if (hit_s) begin
            cnt_inc_s = 1'b1;
            if (cnt_plus_s == tgt_r) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            cnt_inc_s = 1'b0;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (start) begin
          if (start_ok_s) begin
            state_nxt_s = RUN;
            arm_s       = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else if (cfg_we) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Config registers, match counter and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r       <= {MAX_LEN{1'b0}};
      len_r       <= {LW{1'b0}};
      ovl_r       <= 1'b0;
      tgt_r       <= {CNT_W{1'b0}};
      match_count <= {CNT_W{1'b0}};
      match       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (cfg_ld_s) begin
        pat_r <= cfg_pattern;
        len_r <= cfg_len;
        ovl_r <= cfg_overlap;
        tgt_r <= cfg_target;
      end
      if (arm_s) begin
        match_count <= {CNT_W{1'b0}};
      end else if (cnt_inc_s) begin
        match_count <= cnt_plus_s;
      end
      match   <= cnt_inc_s;
      busy    <= (state_nxt_s == RUN);
      done    <= (state_nxt_s == DONE);
      cfg_err <= err_s;
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: constant vector table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_seq_det_ctrl;

  localparam int ML = 8;
  localparam int CW = 8;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we, cfg_overlap, start, abort, bit_valid, bit_in;
  logic [ML-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic [CW-1:0] cfg_target;
  logic          match, busy, done, cfg_err;
  logic [CW-1:0] match_count;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: 0 idle, 1 run, 2 done; q holds the bits that count
  int            m_st, m_cnt, m_len, m_tgt;
  logic [ML-1:0] m_pat;
  logic          m_ovl, m_match, m_err;
  logic          m_q[$];

  typedef struct {
    logic          we;
    logic [ML-1:0] pat;
    logic [LW-1:0] len;
    logic          ovl;
    logic [CW-1:0] tgt;
    logic          st, ab, bv, b;
    logic          em;
    logic [CW-1:0] ec;
    logic          eb, ed, ee;
  } vec_t;
  vec_t tbl[$];

  seq_det_ctrl #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
    .match(match), .match_count(match_count), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic tail_matches();
    for (int k = 0; k < m_len; k++)
      if (m_q[m_q.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_len = 0; m_tgt = 0; m_pat = '0; m_ovl = 1'b0;
    m_match = 1'b0; m_err = 1'b0; m_q.delete();
  endtask

  task automatic model_step();
    m_match = 1'b0;
    m_err   = 1'b0;
    if (abort) begin
      m_st = 0;
    end else if (start && m_st != 1) begin
      if (m_len == 0 || m_len > ML || m_tgt == 0) m_err = 1'b1;
      else begin m_st = 1; m_cnt = 0; m_q.delete(); end
    end else if (m_st == 1) begin
      if (cfg_we) m_err = 1'b1;
      if (bit_valid) begin
        m_q.push_back(bit_in);
        if (m_q.size() > ML) void'(m_q.pop_front());
        if (m_q.size() >= m_len && tail_matches()) begin
          m_match = 1'b1;
          m_cnt++;
          if (!m_ovl) m_q.delete();
          if (m_cnt == m_tgt) m_st = 2;
        end
      end
    end else if (cfg_we) begin
      if (m_st == 0) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
      end else m_err = 1'b1;
    end
  endtask

  // apply one cycle of inputs, advance model and DUT, compare everything
  task automatic drive(input logic we, input logic [ML-1:0] pat, input logic [LW-1:0] len,
                       input logic ovl, input logic [CW-1:0] tgt, input logic st,
                       input logic ab, input logic bv, input logic b);
    cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; cfg_target = tgt;
    start = st; abort = ab; bit_valid = bv; bit_in = b;
    model_step();
    @(posedge clk);
    #1;
    chk("model", {match, match_count, busy, done, cfg_err},
        {m_match, CW'(m_cnt), (m_st == 1), (m_st == 2), m_err});
  endtask

  task automatic cfg(input logic [ML-1:0] p, input logic [LW-1:0] l, input logic o, input logic [CW-1:0] t);
    drive(1'b1, p, l, o, t, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic go();     drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic stop();   drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic gap();    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic sbit(input logic b); drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, b); endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset", {match, match_count, busy, done, cfg_err}, '0);
    rst = 1'b0;
  endtask

  task automatic add(input logic we, input logic [ML-1:0] pat, input logic [LW-1:0] len,
                     input logic ovl, input logic [CW-1:0] tgt, input logic st, input logic ab,
                     input logic bv, input logic b, input logic em, input logic [CW-1:0] ec,
                     input logic eb, input logic ed, input logic ee);
    vec_t v;
    v = '{we, pat, len, ovl, tgt, st, ab, bv, b, em, ec, eb, ed, ee};
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] s0101;
    s0101 = 8'b0101_0101;
    do_reset();

    // non-overlapping 0101, target 8: hits after bits 4 and 8
    add(1, 8'h05, 4'd4, 0, 8'd8, 0, 0, 0, 0,  0, 8'd0, 0, 0, 0);
    add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 1, 1,  0, 8'd0, 1, 0, 0);
    for (int i = 7; i >= 0; i--)
      add(0, 8'h00, 4'd0, 0, 8'd0, 0, 0, 1, s0101[i], (i == 4 || i == 0),
          (i > 4) ? 8'd0 : (i > 0) ? 8'd1 : 8'd2, 1, 0, 0);
    // overlapping, target 2: done after bit 6, later bits ignored
    add(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 0, 0,  0, 8'd2, 0, 0, 0);
    add(1, 8'h05, 4'd4, 1, 8'd2, 0, 0, 0, 0,  0, 8'd2, 0, 0, 0);
    add(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0,  0, 8'd0, 1, 0, 0);
    for (int i = 7; i >= 0; i--)
      add(0, 8'h00, 4'd0, 0, 8'd0, 0, 0, 1, s0101[i], (i == 4 || i == 2),
          (i > 4) ? 8'd0 : (i > 2) ? 8'd1 : 8'd2, (i > 2), (i <= 2), 0);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].tgt,
            tbl[i].st, tbl[i].ab, tbl[i].bv, tbl[i].b);
      chk($sformatf("tbl%0d", i), {match, match_count, busy, done, cfg_err},
          {tbl[i].em, tbl[i].ec, tbl[i].eb, tbl[i].ed, tbl[i].ee});
    end

    // overlapping, target 8: three matches
    stop();
    cfg(8'h05, 4'd4, 1'b1, 8'd8);
    go();
    for (int i = 7; i >= 0; i--) sbit(s0101[i]);
    chk("ovl_count", match_count, 32'd3);

    // len 0 rejected; cfg write during RUN rejected and harmless
    stop();
    cfg(8'h05, 4'd0, 1'b0, 8'd8);
    go();
    chk("len0_err", {cfg_err, busy}, 2'b10);
    cfg(8'h05, 4'd4, 1'b0, 8'd8);
    go();
    cfg(8'h0F, 4'd4, 1'b0, 8'd8);
    chk("run_cfg_err", {cfg_err, busy}, 2'b11);
    sbit(1'b0); sbit(1'b1); sbit(1'b0); sbit(1'b1);
    chk("orig_pattern", {match, match_count}, {1'b1, 8'd1});

    // abort partial, re-arm clears history
    sbit(1'b0); sbit(1'b1); sbit(1'b0);
    stop();
    go();
    sbit(1'b1);
    chk("rearm_clean", {match, match_count}, {1'b0, 8'd0});
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_abort", {busy, done}, 2'b00);

    // asynchronous reset mid-run
    go();
    sbit(1'b0);
    bit_valid = 1'b1; bit_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {match, match_count, busy, done, cfg_err}, '0);
    do_reset();

    // gaps in bit_valid do not disturb the window
    cfg(8'h05, 4'd4, 1'b0, 8'd8);
    go();
    sbit(1'b0); gap(); sbit(1'b1); gap(); sbit(1'b0);
    chk("gap_nomatch", match, 1'b0);
    sbit(1'b1);
    chk("gap_match", {match, match_count}, {1'b1, 8'd1});

    // randomized traffic against the model
    stop();
    for (int n = 0; n < 3000; n++) begin
      logic [LW-1:0] l;
      case ($urandom_range(0, 9))
        0:       l = LW'(0);
        1:       l = LW'($urandom_range(ML + 1, (1 << LW) - 1));
        2:       l = LW'($urandom_range(4, ML));
        default: l = LW'($urandom_range(1, 3));
      endcase
      drive(($urandom_range(0, 7) == 0), ML'($urandom), l, 1'($urandom),
            CW'($urandom_range(0, 6)), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial-pattern detection controller.
- Accepts a configuration: pattern, length, overlap mode and target match count.
- Arms on command, consumes a valid-qualified serial bit stream and counts pattern matches.
- Stops and flags done when the target count is reached.
- Sequences and configures the team's Mealy sequence-detector datapath so firmware can reuse one engine for any pattern up to MAX_LEN bits.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (≥2)
CNT_W, 8, width of match counter and target

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
cfg_we  in  1  configuration write strobe
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
cfg_len  in  $clog2(MAX_LEN+1)  pattern length in bits
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
cfg_target  in  CNT_W  number of matches that completes a run
start  in  1  arm / re-arm pulse
abort  in  1  abandon run, return to IDLE
bit_valid  in  1  bit_in is valid this cycle
bit_in  in  1  serial data bit
match  out  1  one-cycle pulse: a match completed on the previous accepted bit
match_count  out  CNT_W  matches counted in current/last run
busy  out  1  high in RUN
done  out  1  high in DONE
cfg_err  out  1  one-cycle pulse on a rejected config write or start

Behaviour:
- Reset: state=IDLE; match=0, match_count=0, busy=0, done=0, cfg_err=0; config registers cleared (pattern=0, len=0, overlap=0, target=0); history and fill cleared. Reset mid-run aborts immediately.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE); both registered.
- Configuration writes:
  - cfg_we in IDLE latches all four cfg_* fields.
  - cfg_we in RUN or DONE is ignored, pulses cfg_err the next cycle, and leaves config unchanged.
- Start validation and arming (IDLE or DONE):
  - Start is rejected if latched len==0, len>MAX_LEN or target==0. Rejection pulses cfg_err and the state is unchanged.
  - Otherwise: next state RUN, match_count←0, history←0, fill←0.
  - bit_valid on the start cycle is ignored.
- Priority: abort beats start beats cfg_we when they coincide.
- abort in RUN or DONE → IDLE; match_count retained; no match pulse. abort in IDLE has no effect.
- RUN, per accepted bit (bit_valid=1):
  - history←{history[MAX_LEN-2:0], bit_in}; fill←min(fill+1, MAX_LEN).
  - Hit when fill_next ≥ len and history_next[len-1:0]==pattern[len-1:0].
  - On hit, next edge: match=1 and match_count+1. If overlap=0, fill←0 (history bits are retained but not compared until fill refills).
  - If match_count+1 == target: state→DONE on the same edge.
- Latency: match pulse, counter update and done are all one cycle after the accepted bit.
- Bits arriving in IDLE or DONE are ignored. match_count never exceeds target. bit_valid=0 cycles leave history and fill unchanged.
- DONE: holds match_count; start re-arms (validation applies); abort → IDLE.

Decomposition:
- Package seq_det_pkg:
  - state enum state_t {IDLE, RUN, DONE}
  - MAX_LEN_DEF=8, CNT_W_DEF=8
  - localparam LEN_W = $clog2(MAX_LEN+1)
- Sub-module seq_det_window:
  - Holds the history shift register and fill counter, with the masked length-compare.
  - Inputs: shift, clear, bit, pattern, len. Output: hit (combinational on next-state history).
- The top level holds the FSM, config registers and counter.

Test Plan:
1. pattern=0101, len=4, overlap=0, target=8, start; stream 0,1,0,1,0,1,0,1 → match pulses after bits 4 and 8; match_count=2; busy=1, done=0.
2. Same config with overlap=1, same stream → match pulses after bits 4, 6, 8; match_count=3.
3. overlap=1, target=2, stream 0,1,0,1,0,1,0,1 → done=1 and busy=0 one cycle after bit 6; bits 7–8 ignored; match_count stays 2.
4. len=0 then start → cfg_err pulse 1 cycle, busy=0. Then cfg_we during RUN with pattern=1111 → cfg_err pulse; original pattern still matches 0101.
5. abort after bits 0,1,0; then start and feed 1 → no match (history cleared); match_count=0. Start and abort in the same cycle → IDLE.
6. rst asserted asynchronously mid-RUN with bit_valid=1 → all outputs 0 immediately. Gaps of bit_valid=0 inside 0,_,1,_,0,1 → one match after the final bit.
